// File: rtl/gray_conv_ctrl.sv
// gray_conv_ctrl
//   Sequencing controller and I/O stage that sits in front of a bit-serial
//   binary<->Gray converter datapath. It takes one byte and a direction bit over
//   a valid/ready handshake and holds the byte on the datapath input. It then
//   walks the datapath strobes from MSB to LSB, captures the finished result,
//   and presents that result downstream over a second valid/ready handshake.
//
//   Fixed latency: out_valid rises 18 cycles after the accept cycle.
//
// Parameters
//   DATA_W          byte width; only 8 is supported (elaboration error otherwise)
//   ACCEPT_ON_DRAIN 1: a new byte may be accepted in the cycle the result drains
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   in_valid/in_ready/in_data/in_mode   upstream handshake, mode 0=bin->Gray, 1=Gray->bin
//   dp_data_in                held input byte driving the datapath
//   dp_data_out               datapath result byte
//   R1_in..R4_in, bit_index, R1_bit_sel, load_R2_bit,
//   use_R1_for_R3, use_R1_for_R4        registered datapath control strobes
//   out_valid/out_ready/out_data        downstream handshake
//   busy                      high whenever not idle
//   chk_err                   result self-check flag
//
// Build option
//   GRAY_CTRL_SELFCHK_EN      when defined, compares the datapath result with a
//                             locally computed reference; otherwise chk_err = 0.
module gray_conv_ctrl #(
   parameter int DATA_W          = 8,
   parameter bit ACCEPT_ON_DRAIN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_mode,
   output logic [DATA_W-1:0] dp_data_in,
   input  logic [DATA_W-1:0] dp_data_out,
   output logic              R1_in,
   output logic              R2_in,
   output logic              R3_in,
   output logic              R4_in,
   output logic [2:0]        bit_index,
   output logic              R1_bit_sel,
   output logic              load_R2_bit,
   output logic              use_R1_for_R3,
   output logic              use_R1_for_R4,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              chk_err
);

   generate
      if (DATA_W != 8) begin : g_width_check
         $error("gray_conv_ctrl: DATA_W must be 8");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_MSB  = 3'd2,
      S_OPS  = 3'd3,
      S_WR   = 3'd4,
      S_CAP  = 3'd5,
      S_OUT  = 3'd6
   } state_t;

   state_t     state_r;
   state_t     state_nxt;
   logic [2:0] idx_r;
   logic [2:0] idx_nxt;
   logic       mode_r;
   logic       accept;
   logic       bit_phase_nxt;

   // in_ready is the only output allowed to follow out_ready combinationally.
   assign in_ready = (state_r == S_IDLE) |
                     ((ACCEPT_ON_DRAIN != 1'b0) & (state_r == S_OUT) & out_ready);
   assign accept   = in_valid & in_ready;

   // bit_index is the index register itself; it reads 7 outside the bit loop.
   assign bit_index     = idx_r;
   assign bit_phase_nxt = (state_nxt == S_OPS) | (state_nxt == S_WR);
   assign R2_in         = 1'b0;

   // Next-state and bit-counter decode.
   always_comb begin
      state_nxt = state_r;
      idx_nxt   = idx_r;
      case (state_r)
         S_IDLE: begin
            if (accept) state_nxt = S_LOAD;
            else        state_nxt = S_IDLE;
         end
         S_LOAD: state_nxt = S_MSB;
         S_MSB: begin
            state_nxt = S_OPS;
            idx_nxt   = 3'd6;
         end
         S_OPS: state_nxt = S_WR;
         S_WR: begin
            if (idx_r == 3'd0) begin
               state_nxt = S_CAP;
               idx_nxt   = 3'd7;
            end else begin
               state_nxt = S_OPS;
               idx_nxt   = idx_r - 3'd1;
            end
         end
         S_CAP: state_nxt = S_OUT;
         S_OUT: begin
            if (!out_ready)  state_nxt = S_OUT;
            else if (accept) state_nxt = S_LOAD;
            else             state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
            idx_nxt   = 3'd7;
         end
      endcase
   end

   // State register with strobes decoded from the next state, so every
   // datapath control is a flop output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= S_IDLE;
         idx_r         <= 3'd7;
         mode_r        <= 1'b0;
         dp_data_in    <= {DATA_W{1'b0}};
         out_data      <= {DATA_W{1'b0}};
         R1_in         <= 1'b0;
         R3_in         <= 1'b0;
         R4_in         <= 1'b0;
         load_R2_bit   <= 1'b0;
         R1_bit_sel    <= 1'b0;
         use_R1_for_R3 <= 1'b0;
         use_R1_for_R4 <= 1'b0;
         out_valid     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state_r       <= state_nxt;
         idx_r         <= idx_nxt;
         R1_in         <= (state_nxt == S_LOAD);
         R3_in         <= (state_nxt == S_OPS);
         R4_in         <= (state_nxt == S_OPS);
         load_R2_bit   <= (state_nxt == S_MSB) | (state_nxt == S_WR);
         // Mode 0 pairs R1[i+1] with R1[i]; mode 1 pairs R1[i] with R2[i+1].
         use_R1_for_R3 <= bit_phase_nxt;
         R1_bit_sel    <= bit_phase_nxt & ~mode_r;
         use_R1_for_R4 <= bit_phase_nxt & ~mode_r;
         out_valid     <= (state_nxt == S_OUT);
         busy          <= (state_nxt != S_IDLE);
         if (accept) begin
            dp_data_in <= in_data;
            mode_r     <= in_mode;
         end
         if (state_r == S_CAP) begin
            out_data <= dp_data_out;
         end
      end
   end

`ifdef GRAY_CTRL_SELFCHK_EN
   function automatic logic [DATA_W-1:0] bin_to_gray(input logic [DATA_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR running from the MSB down.
   function automatic logic [DATA_W-1:0] gray_to_bin(input logic [DATA_W-1:0] g);
      logic [DATA_W-1:0] b;
      logic              acc;
      b   = {DATA_W{1'b0}};
      acc = 1'b0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         acc  = acc ^ g[i];
         b[i] = acc;
      end
      return b;
   endfunction

   logic [DATA_W-1:0] chk_expect;
   logic              chk_err_r;

   assign chk_expect = mode_r ? gray_to_bin(dp_data_in) : bin_to_gray(dp_data_in);
   assign chk_err    = chk_err_r;

   // Result check: set at capture so it rises with out_valid, cleared on drain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chk_err_r <= 1'b0;
      end else if (state_r == S_CAP) begin
         chk_err_r <= (dp_data_out != chk_expect);
      end else if ((state_r == S_OUT) && out_ready) begin
         chk_err_r <= 1'b0;
      end
   end
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_conv_ctrl.sv
// tb_gray_conv_ctrl
//   Self-checking bench for gray_conv_ctrl. A small emulation of the bit-serial
//   datapath reacts to the controller strobes, so wrong strobes yield wrong bytes.
//   A cycle-offset reference model (cycles since accept) predicts every output
//   on every cycle, and directed cases pin literal results.
module tb_gray_conv_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_mode;
   logic [7:0] dp_data_in;
   logic [7:0] dp_data_out;
   logic       R1_in, R2_in, R3_in, R4_in;
   logic [2:0] bit_index;
   logic       R1_bit_sel, load_R2_bit, use_R1_for_R3, use_R1_for_R4;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       busy;
   logic       chk_err;

   int n_cmp  = 0;
   int n_fail = 0;
   bit corrupt = 1'b0;

   gray_conv_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
      .dp_data_in(dp_data_in), .dp_data_out(dp_data_out),
      .R1_in(R1_in), .R2_in(R2_in), .R3_in(R3_in), .R4_in(R4_in),
      .bit_index(bit_index), .R1_bit_sel(R1_bit_sel), .load_R2_bit(load_R2_bit),
      .use_R1_for_R3(use_R1_for_R3), .use_R1_for_R4(use_R1_for_R4),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .chk_err(chk_err)
   );

   always #5 clk = ~clk;

   // Datapath emulation driven only by the strobes.
   logic [7:0] dp_r1, dp_r2;
   logic       dp_r3, dp_r4;
   logic [2:0] up_idx;
   logic [2:0] sel_idx;
   assign up_idx      = bit_index + 3'd1;
   assign sel_idx     = R1_bit_sel ? up_idx : bit_index;
   assign dp_data_out = corrupt ? 8'h00 : dp_r2;

   always @(posedge clk) begin
      if (R1_in) dp_r1 <= dp_data_in;
      if (R3_in) dp_r3 <= use_R1_for_R3 ? dp_r1[sel_idx] : 1'b0;
      if (R4_in) dp_r4 <= use_R1_for_R4 ? dp_r1[bit_index] : dp_r2[up_idx];
      if (load_R2_bit) dp_r2[bit_index] <= (bit_index == 3'd7) ? dp_r1[7] : (dp_r3 ^ dp_r4);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_convert(input logic [7:0] b, input bit m);
      logic [7:0] r;
      bit acc;
      if (!m) return b ^ (b >> 1);
      acc = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         acc  = acc ^ b[i];
         r[i] = acc;
      end
      return r;
   endfunction

   // Reference model: k = cycles since accept (-1 when idle), checked each negedge.
   int         k = -1;
   logic [7:0] cur_byte, cur_res;
   bit         cur_mode, cur_corrupt;

   always @(negedge clk) begin
      bit exp_ir, acc, loop;
      if (!rst) begin
         chk("rst_strobes", 32'({R1_in, R2_in, R3_in, R4_in, load_R2_bit, R1_bit_sel,
                                 use_R1_for_R3, use_R1_for_R4, out_valid, busy, chk_err}), 32'd0);
         chk("rst_dp_data_in", 32'(dp_data_in), 32'd0);
         chk("rst_out_data", 32'(out_data), 32'd0);
         chk("rst_bit_index", 32'(bit_index), 32'd7);
         k = -1;
      end else begin
         exp_ir = (k < 0) || (k >= 18 && out_ready);
         loop   = (k >= 3 && k <= 16);
         chk("in_ready", 32'(in_ready), 32'(exp_ir));
         chk("busy", 32'(busy), 32'(k >= 1));
         chk("R1_in", 32'(R1_in), 32'(k == 1));
         chk("R2_in", 32'(R2_in), 32'd0);
         chk("R3_in", 32'(R3_in), 32'(loop && (k % 2 == 1)));
         chk("R4_in", 32'(R4_in), 32'(loop && (k % 2 == 1)));
         chk("load_R2_bit", 32'(load_R2_bit), 32'(k >= 2 && k <= 16 && (k % 2 == 0)));
         chk("use_R1_for_R3", 32'(use_R1_for_R3), 32'(loop));
         chk("R1_bit_sel", 32'(R1_bit_sel), 32'(loop && !cur_mode));
         chk("use_R1_for_R4", 32'(use_R1_for_R4), 32'(loop && !cur_mode));
         chk("out_valid", 32'(out_valid), 32'(k >= 18));
         chk("chk_err", 32'(chk_err), 32'(k >= 18 && cur_corrupt));
         if (k >= 2 && k <= 16)
            chk("bit_index", 32'(bit_index), 32'((k == 2) ? 7 : 6 - (k - 3) / 2));
         if (k >= 1)
            chk("dp_data_in", 32'(dp_data_in), 32'(cur_byte));
         if (k >= 18)
            chk("out_data", 32'(out_data), 32'(cur_corrupt ? 8'h00 : cur_res));
         acc = in_valid && exp_ir;
         if (k >= 18 && out_ready) k = -1;
         else if (k >= 1 && k < 18) k = k + 1;
         if (acc) begin
            k           = 1;
            cur_byte    = in_data;
            cur_mode    = in_mode;
            cur_res     = ref_convert(in_data, in_mode);
            cur_corrupt = corrupt;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input bit m);
      bit got = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      chk("accept_timeout", 32'(got), 32'd1);
      step();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic wait_out(output int n);
      n = 0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         n++;
         if (out_valid) break;
      end
   endtask

   task automatic do_op(input logic [7:0] d, input bit m, input logic [7:0] lit);
      int n;
      send(d, m);
      wait_out(n);
      chk("latency", 32'(n), 32'd18);
      chk("lit_result", 32'(out_data), 32'(lit));
      chk("lit_chk_err", 32'(chk_err), 32'(corrupt));
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_mode = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      step();

      do_op(8'hB4, 1'b0, 8'hEE);
      do_op(8'hEE, 1'b1, 8'hB4);
      do_op(8'h80, 1'b1, 8'hFF);
      do_op(8'hFF, 1'b0, 8'h80);
      do_op(8'h00, 1'b0, 8'h00);

      // Backpressure for 5 cycles, then a new byte accepted on the drain cycle.
      out_ready = 1'b0;
      send(8'h5A, 1'b0);
      wait_out(n);
      chk("bp_first", 32'(out_data), 32'h77);
      for (int c = 0; c < 5; c++) begin
         step();
         @(negedge clk);
         chk("bp_hold_data", 32'(out_data), 32'h77);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      step();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hC3; in_mode = 1'b1;
      @(negedge clk);
      chk("drain_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_R1_in", 32'(R1_in), 32'd1);
      wait_out(n);
      chk("b2b_result", 32'(out_data), 32'h82);
      step();

      // Abort by reset at cycle 8, then a clean conversion.
      send(8'hB4, 1'b0);
      repeat (7) step();
      rst = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      step();
      rst = 1'b1;
      step();
      do_op(8'h3C, 1'b0, 8'h22);

`ifdef GRAY_CTRL_SELFCHK_EN
      corrupt = 1'b1;
      do_op(8'hB4, 1'b0, 8'h00);
      corrupt = 1'b0;
      step();
      @(negedge clk);
      chk("chk_err_cleared", 32'(chk_err), 32'd0);
      step();
`endif

      // Randomized traffic with occasional resets and random backpressure.
      for (int c = 0; c < 2000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         in_mode   = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 299) != 0);
         step();
      end
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (25) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_conv_ctrl.md
Name: gray_conv_ctrl

Overview:
- Sequencing controller and I/O stage directly upstream of the bit-serial binary/Gray converter datapath.
- Accepts one byte plus a direction bit over a valid/ready handshake and holds the byte on the datapath input.
- Generates every datapath control strobe bit by bit, MSB to LSB, then captures the datapath result and presents it downstream over a valid/ready handshake.

Parameters:
- DATA_W, 8: byte width. Only 8 is supported; any other value raises an elaboration error.
- ACCEPT_ON_DRAIN, 1: when 1, in_ready is also high in S_OUT while out_ready=1, so a new byte is accepted in the same cycle the result drains. When 0, input is accepted only in S_IDLE.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  upstream byte valid
- in_ready  out  1  controller can accept a byte
- in_data  in  8  byte to convert
- in_mode  in  1  0 = binary->Gray, 1 = Gray->binary; sampled with in_data
- dp_data_in  out  8  registered hold of in_data, drives datapath data_in
- dp_data_out  in  8  datapath result byte
- R1_in, R2_in, R3_in, R4_in  out  1 each  datapath register loads (R2_in always 0)
- bit_index  out  3  current bit
- R1_bit_sel  out  1  R3 source: 1 = R1[i+1], 0 = R1[i]
- load_R2_bit  out  1  write one result bit
- use_R1_for_R3, use_R1_for_R4  out  1 each  operand source selects
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  8  captured result
- busy  out  1  high in every state except S_IDLE
- chk_err  out  1  self-check flag (see Optional Feature)

Behaviour:
- Reset: state S_IDLE. All strobes, dp_data_in, out_data, out_valid, busy and chk_err are 0. bit_index is 7. in_ready is 1 after reset releases.
- Reset asserted mid-operation aborts immediately. No output is produced for the aborted byte. The datapath R2 is not cleared, because the next operation rewrites all 8 bits.
- Cycle numbering: the accept cycle (in_valid & in_ready) is cycle 0.
- S_IDLE: in_ready=1. On accept, latch dp_data_in<=in_data and mode<=in_mode, then go to S_LOAD.
- S_LOAD (cycle 1): R1_in=1. Next state S_MSB.
- S_MSB (cycle 2): bit_index=7, load_R2_bit=1. The datapath copies the MSB. Set i=6 and go to S_OPS.
- S_OPS: bit_index=i, R3_in=R4_in=1. Operand selects by mode:
  - mode 0: use_R1_for_R3=1, R1_bit_sel=1, use_R1_for_R4=1.
  - mode 1: use_R1_for_R3=1, R1_bit_sel=0, use_R1_for_R4=0 (R4 takes R2[i+1]).
  - Next state S_WR.
- S_WR: bit_index=i, load_R2_bit=1, selects held from S_OPS. If i=0 go to S_CAP; otherwise i<=i-1 and go to S_OPS.
- S_OPS/S_WR pairs occupy cycles 3..16; the bit-0 write is at cycle 16.
- S_CAP (cycle 17): out_data<=dp_data_out. Next state S_OUT.
- S_OUT: out_valid=1 from cycle 18. Fixed latency is 18 cycles from accept to out_valid.
  - out_data and out_valid hold stable while out_ready=0.
  - On out_ready=1: go to S_IDLE, or go to S_LOAD if ACCEPT_ON_DRAIN=1 and a byte is accepted in that cycle.
- All strobes are 0 outside the states that name them. Every strobe is registered-decode from state: no combinational path from in_*/out_ready to any dp_* output.
- in_valid while busy: ignored; in_data is not sampled.

Optional Feature:
- Macro GRAY_CTRL_SELFCHK_EN.
- Defined: in S_CAP the block computes the expected result from the held byte. Mode 0 uses b^(b>>1); mode 1 uses the prefix-XOR from the MSB down.
  - chk_err is registered and asserted with out_valid when dp_data_out differs from the expected result.
  - chk_err clears when the result drains.
- Undefined: chk_err is tied to 0 and no checker logic is present.

Test Plan:
- in_mode=0, in_data=0xB4, out_ready=1 -> out_valid at cycle 18, out_data=0xEE, chk_err=0.
- in_mode=1, in_data=0xEE -> out_data=0xB4. in_mode=1, in_data=0x80 -> out_data=0xFF.
- in_mode=0, in_data=0xFF -> 0x80. in_mode=0, in_data=0x00 -> 0x00. Check the strobe trace: R1_in at cycle 1 only; load_R2_bit at cycles 2,4,...,16 with bit_index 7,6,...,0.
- out_ready held low 5 cycles after out_valid -> out_data stable, in_ready=0 (ACCEPT_ON_DRAIN=1 until out_ready). Back-to-back byte accepted on the drain cycle -> R1_in the next cycle.
- rst pulsed low at cycle 8 of a conversion -> all outputs 0 immediately, no out_valid. A following 0x3C mode 0 -> 0x22.
- SELFCHK build: force dp_data_out=0x00 for in_data=0xB4 mode 0 -> chk_err=1 with out_valid.
